// File: rtl/xg_lsu.sv
// xg_lsu: load/store unit driving a word-only data memory.
// One request in flight at a time. Loads are extracted and extended from the
// addressed memory word. Byte and halfword stores use read-modify-write,
// because the memory only accepts whole-word writes.
module xg_lsu #(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  // pipeline request
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [XLEN-1:0]      req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  input  logic [ADDR_SIZE-1:0] req_pc,
  // pipeline response
  output logic                 resp_valid,
  output logic [XLEN-1:0]      resp_rdata,
  output logic                 resp_err,
  // data memory
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_a,
  output logic [XLEN-1:0]      mem_wd,
  output logic [ADDR_SIZE-1:0] mem_pc,
  input  logic [XLEN-1:0]      mem_rd
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LD   = 3'd1,
    S_RD   = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  // funct3[1:0] encodes the access size for both loads and stores
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [XLEN-1:0]       r_addr;
  logic [XLEN-1:0]       r_wdata;
  logic [ADDR_SIZE-1:0]  r_pc;
  logic [XLEN-1:0]       r_merge;
  logic [XLEN-1:0]       r_rdata;
  logic                  r_err;

  logic                  w_fire;
  logic                  w_legal;
  logic                  w_misaligned;
  logic                  w_req_err;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [XLEN-1:0]       w_load_data;
  logic [XLEN-1:0]       w_store_word;
  logic                  w_idle;

  assign w_idle = (r_state == S_IDLE);
  assign w_fire = req_valid && w_idle;

  // Decode the incoming request: legal funct3 for its direction, natural alignment
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    w_legal      = 1'b0;
    w_misaligned = 1'b0;
    if (req_we) begin
      w_legal = (req_funct3 == {1'b0, SZ_B}) || (req_funct3 == {1'b0, SZ_H}) ||
                (req_funct3 == {1'b0, SZ_W});
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
        default:                                w_legal = 1'b0;
      endcase
    end
    case (req_funct3[1:0])
      SZ_H:    w_misaligned = req_addr[0];
      SZ_W:    w_misaligned = |req_addr[1:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_req_err = !w_legal || w_misaligned;

  // Next-state selection; only IDLE branches, every other state has one successor
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_fire) begin
          if (w_req_err)                       w_state_nxt = S_RESP;
          else if (!req_we)                    w_state_nxt = S_LD;
          else if (req_funct3[1:0] == SZ_W)    w_state_nxt = S_WR;
          else                                 w_state_nxt = S_RD;
        end
      end
      S_LD:    w_state_nxt = S_RESP;
      S_RD:    w_state_nxt = S_WR;
      S_WR:    w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Little-endian lane extraction and sign/zero extension of the memory word
  always_comb begin
    w_byte      = mem_rd[{r_addr[1:0], 3'b000} +: 8];
    w_half      = mem_rd[{r_addr[1], 4'b0000} +: 16];
    w_load_data = mem_rd;
    case (r_funct3)
      3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
      3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
      3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
      default: w_load_data = mem_rd;
    endcase
  end

  // Word to write: full store data for sw, otherwise the old word with one lane replaced
  always_comb begin
    w_store_word = r_merge;
    case (r_funct3[1:0])
      SZ_B:    w_store_word[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      SZ_H:    w_store_word[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      default: w_store_word = r_wdata;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Request capture, read-modify-write buffer and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_pc     <= '0;
      r_merge  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_fire) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_pc     <= req_pc;
      end
      if (r_state == S_RD) r_merge <= mem_rd;
      // Response fields change only on entry to RESP, then hold until the next one
      if (w_state_nxt == S_RESP) begin
        r_rdata <= (r_state == S_LD && !r_we) ? w_load_data : '0;
        r_err   <= (r_state == S_IDLE);
      end
    end
  end

  assign req_ready  = w_idle;
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // A reset arriving while in WR must block the write in that same cycle
  assign mem_we = (r_state == S_WR) && !reset;
  assign mem_a  = w_idle ? '0 : {r_addr[XLEN-1:2], 2'b00};
  assign mem_pc = w_idle ? '0 : r_pc;
  assign mem_wd = (r_state == S_WR) ? w_store_word : '0;

endmodule

// File: tb/tb_xg_lsu.sv
// Self-checking bench for xg_lsu: word memory model plus a byte-level reference model.
module tb_xg_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_pc;
  logic [31:0] mem_rd;

  int n_checks = 0;
  int n_fail   = 0;

  xg_lsu #(.XLEN(32), .ADDR_SIZE(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_pc(mem_pc), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Word memory seen by the DUT: combinational read, write on clock edge
  logic [31:0] mem [0:255];
  assign mem_rd = mem[mem_a[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[9:2]] <= mem_wd;

  // Reference model: plain byte-addressed memory
  logic [7:0] model [0:1023];

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int b;
    b = int'(a[9:0]) & ~3;
    return {model[b+3], model[b+2], model[b+1], model[b]};
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] w);
    int b;
    b = int'(a[9:0]) & ~3;
    mem[b/4] = w;
    for (int i = 0; i < 4; i++) model[b+i] = 8'(w >> (8*i));
  endtask

  // Expected outcome of one request, and model memory update for stores
  task automatic model_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic e_err,
                          output logic [31:0] e_rdata, output int e_lat, output int e_nwe,
                          output int e_off, output logic [31:0] e_wd);
    int size;
    logic legal;
    longint val;
    int base;
    case (f3[1:0])
      2'd0:    size = 1;
      2'd1:    size = 2;
      2'd2:    size = 4;
      default: size = 1;
    endcase
    if (we) legal = (f3 <= 3'd2);
    else    legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    e_err   = !legal || ((int'(addr[9:0]) % size) != 0);
    e_rdata = '0;
    e_nwe   = 0;
    e_off   = 0;
    e_wd    = '0;
    base    = int'(addr[9:0]);
    if (e_err) begin
      e_lat = 1;
    end else if (!we) begin
      val = 0;
      for (int i = 0; i < size; i++) val = val + (longint'(model[base+i]) << (8*i));
      if (!f3[2] && size < 4 && ((val >> (8*size-1)) & 1) == 1)
        val = val - (longint'(1) << (8*size));
      e_rdata = 32'(val);
      e_lat   = 2;
    end else begin
      for (int i = 0; i < size; i++) model[base+i] = 8'(wdata >> (8*i));
      e_nwe = 1;
      e_off = (size == 4) ? 1 : 2;
      e_lat = (size == 4) ? 2 : 3;
      e_wd  = model_word(addr);
    end
  endtask

  // Drive one request and observe it; offsets are cycles after the accept cycle
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] pc,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int nwe, output int we_off, output logic [31:0] wa,
                        output logic [31:0] wd, output logic [31:0] wpc);
    int wait_cnt;
    lat = -1; rdata = 'x; err = 1'bx; nwe = 0; we_off = -1; wa = 'x; wd = 'x; wpc = 'x;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_pc = pc;
    wait_cnt = 0;
    while (!req_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (mem_we) begin
        nwe++; we_off = k; wa = mem_a; wd = mem_wd; wpc = mem_pc;
      end
      if (resp_valid) begin
        lat = k; rdata = resp_rdata; err = resp_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pulses: resp_valid=%b mem_we=%b, required 0 0", resp_valid, mem_we);
    end
    n_checks++;
    if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_resp: rdata=%h err=%b, required 0 0", resp_rdata, resp_err);
    end
    n_checks++;
    if (mem_a !== 32'h0 || mem_wd !== 32'h0 || mem_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mem_bus: a=%h wd=%h pc=%h, required all 0", mem_a, mem_wd, mem_pc);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: req_ready=%b, required 1", req_ready);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s   [4] = '{3'b000, 3'b100, 3'b001, 3'b010};
    logic [31:0] addrs [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] exps  [4] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h8899AABB};
    int lat, nwe, off;
    logic [31:0] rd, wa, wd, wpc;
    logic err;
    poke(32'h10, 32'h8899AABB);
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, f3s[i], addrs[i], 32'hFFFF_FFFF, 32'h100 + 32'(i), lat, rd, err, nwe, off, wa, wd, wpc);
      n_checks++;
      if (lat !== 2 || rd !== exps[i] || err !== 1'b0 || nwe !== 0) begin
        n_fail++;
        $display("FAIL load_%0d: lat=%0d rdata=%h err=%b nwe=%0d, required 2 %h 0 0",
                 i, lat, rd, err, nwe, exps[i]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h8899AABB) begin
      n_fail++;
      $display("FAIL load_hold: resp_valid=%b rdata=%h, required 0 8899aabb", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_sub_word_stores();
    int lat, nwe, off;
    logic [31:0] rd, wa, wd, wpc;
    logic err;
    poke(32'h20, 32'h11223344);
    run_op(1'b1, 3'b000, 32'h21, 32'hDEADBEEF, 32'h44, lat, rd, err, nwe, off, wa, wd, wpc);
    n_checks++;
    if (nwe !== 1 || off !== 2 || wa !== 32'h20 || wd !== 32'h1122EF44) begin
      n_fail++;
      $display("FAIL sb_write: nwe=%0d off=%0d a=%h wd=%h, required 1 2 00000020 1122ef44",
               nwe, off, wa, wd);
    end
    n_checks++;
    if (lat !== 3 || err !== 1'b0 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL sb_resp: lat=%0d err=%b rdata=%h, required 3 0 0", lat, err, rd);
    end
    run_op(1'b1, 3'b001, 32'h22, 32'h0000CAFE, 32'h48, lat, rd, err, nwe, off, wa, wd, wpc);
    n_checks++;
    if (mem[8] !== 32'hCAFEEF44 || lat !== 3 || nwe !== 1) begin
      n_fail++;
      $display("FAIL sh_word: mem=%h lat=%0d nwe=%0d, required cafeef44 3 1", mem[8], lat, nwe);
    end
  endtask

  task automatic test_sw();
    int lat, nwe, off;
    logic [31:0] rd, wa, wd, wpc;
    logic err;
    poke(32'h40, 32'h0);
    run_op(1'b1, 3'b010, 32'h40, 32'h12345678, 32'h80, lat, rd, err, nwe, off, wa, wd, wpc);
    n_checks++;
    if (nwe !== 1 || off !== 1 || wa !== 32'h40 || wd !== 32'h12345678 || wpc !== 32'h80) begin
      n_fail++;
      $display("FAIL sw_write: nwe=%0d off=%0d a=%h wd=%h pc=%h, required 1 1 00000040 12345678 00000080",
               nwe, off, wa, wd, wpc);
    end
    n_checks++;
    if (lat !== 2 || rd !== 32'h0 || err !== 1'b0 || mem[16] !== 32'h12345678) begin
      n_fail++;
      $display("FAIL sw_resp: lat=%0d rdata=%h err=%b mem=%h, required 2 0 0 12345678",
               lat, rd, err, mem[16]);
    end
  endtask

  task automatic test_errors();
    logic        wes   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s   [4] = '{3'b010, 3'b001, 3'b011, 3'b011};
    logic [31:0] addrs [4] = '{32'h41, 32'h43, 32'h40, 32'h40};
    int lat, nwe, off;
    logic [31:0] rd, wa, wd, wpc;
    logic err;
    for (int i = 0; i < 4; i++) begin
      run_op(wes[i], f3s[i], addrs[i], 32'hA5A5A5A5, 32'h200, lat, rd, err, nwe, off, wa, wd, wpc);
      n_checks++;
      if (lat !== 1 || err !== 1'b1 || nwe !== 0 || rd !== 32'h0 || mem[16] !== 32'h12345678) begin
        n_fail++;
        $display("FAIL error_%0d: lat=%0d err=%b nwe=%0d rdata=%h mem=%h, required 1 1 0 0 12345678",
                 i, lat, err, nwe, rd, mem[16]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (resp_err !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL error_hold: err=%b valid=%b, required 1 0", resp_err, resp_valid);
    end
  endtask

  task automatic test_reset_mid_wr();
    int nwe, nresp, nready;
    poke(32'h20, 32'h11223344);
    nwe = 0; nresp = 0; nready = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h21; req_wdata = 32'h000000A5; req_pc = 32'h300;
    @(posedge clk); #1;   // accepted, now in RD
    req_valid = 1'b0;
    @(posedge clk); #1;   // now in WR
    reset = 1'b1;
    @(negedge clk);
    if (mem_we) nwe++;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (mem_we) nwe++;
      if (resp_valid) nresp++;
      if (k == 0 && req_ready) nready++;
    end
    n_checks++;
    if (nwe !== 0 || mem[8] !== 32'h11223344) begin
      n_fail++;
      $display("FAIL reset_wr_write: mem_we_seen=%0d mem=%h, required 0 11223344", nwe, mem[8]);
    end
    n_checks++;
    if (nresp !== 0 || nready !== 1 || resp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_wr_resp: resp_seen=%0d ready_next=%0d rdata=%h, required 0 1 0",
               nresp, nready, resp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int acc [2];
    int rsp [2];
    int na, nr;
    logic [31:0] val, rd2;
    val = $urandom;
    na = 0; nr = 0; rd2 = 'x;
    acc[0] = -1; acc[1] = -1; rsp[0] = -1; rsp[1] = -1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h80; req_wdata = val; req_pc = 32'h400;
    for (int k = 0; k < 12; k++) begin
      if (req_valid && req_ready && na < 2) begin acc[na] = k; na++; end
      if (resp_valid && nr < 2) begin
        rsp[nr] = k; nr++;
        if (nr == 1) begin
          req_we = 1'b0; req_funct3 = 3'b010; req_wdata = 32'h0; req_pc = 32'h404;
        end else begin
          rd2 = resp_rdata;
          req_valid = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_checks++;
    if (acc[0] !== 0 || rsp[0] !== 2 || acc[1] !== 3 || rsp[1] !== 5) begin
      n_fail++;
      $display("FAIL b2b_timing: acc=%0d,%0d resp=%0d,%0d, required 0,3 2,5",
               acc[0], acc[1], rsp[0], rsp[1]);
    end
    n_checks++;
    if (rd2 !== val) begin
      n_fail++;
      $display("FAIL b2b_data: rdata=%h, required %h", rd2, val);
    end
  endtask

  task automatic test_random();
    int lat, nwe, off, e_lat, e_nwe, e_off;
    logic [31:0] rd, wa, wd, wpc, e_rd, e_wd, addr, wdata, pc, mask;
    logic err, e_err, we;
    logic [2:0] f3;
    int sel;
    for (int w = 0; w < 256; w++) poke(32'(w*4), $urandom);
    for (int i = 0; i < 80; i++) begin
      we  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel == 0)   f3 = 3'($urandom_range(0, 7));
      else if (we)    f3 = 3'($urandom_range(0, 2));
      else begin
        sel = $urandom_range(0, 4);
        f3  = (sel == 3) ? 3'd4 : (sel == 4) ? 3'd5 : 3'(sel);
      end
      addr = 32'($urandom_range(0, 1023));
      mask = (f3[1:0] == 2'd2) ? 32'h3 : (f3[1:0] == 2'd1) ? 32'h1 : 32'h0;
      if ($urandom_range(0, 3) != 0) addr = addr & ~mask;
      wdata = $urandom;
      pc    = $urandom;
      model_op(we, f3, addr, wdata, e_err, e_rd, e_lat, e_nwe, e_off, e_wd);
      run_op(we, f3, addr, wdata, pc, lat, rd, err, nwe, off, wa, wd, wpc);
      n_checks++;
      if (lat !== e_lat || err !== e_err || rd !== e_rd || nwe !== e_nwe) begin
        n_fail++;
        $display("FAIL rand_%0d resp (we=%b f3=%0d a=%h): lat=%0d err=%b rdata=%h nwe=%0d, required %0d %b %h %0d",
                 i, we, f3, addr, lat, err, rd, nwe, e_lat, e_err, e_rd, e_nwe);
      end
      if (e_nwe == 1) begin
        n_checks++;
        if (off !== e_off || wa !== (addr & ~32'h3) || wd !== e_wd || wpc !== pc) begin
          n_fail++;
          $display("FAIL rand_%0d write: off=%0d a=%h wd=%h pc=%h, required %0d %h %h %h",
                   i, off, wa, wd, wpc, e_off, addr & ~32'h3, e_wd, pc);
        end
      end
      n_checks++;
      if (mem[addr[9:2]] !== model_word(addr)) begin
        n_fail++;
        $display("FAIL rand_%0d mem: word=%h, required %h", i, mem[addr[9:2]], model_word(addr));
      end
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; req_pc = '0;
    for (int w = 0; w < 256; w++) poke(32'(w*4), 32'h0);
    test_reset();
    test_loads();
    test_sub_word_stores();
    test_sw();
    test_errors();
    test_reset_mid_wr();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
